// File: rtl/blink_stream_bridge_pkg.sv
// blink_stream_bridge_pkg: shared state type, frame layout and operand widths for the bridge
package blink_stream_bridge_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SEND} state_t;
  localparam int K0_WORDS = 32;
  localparam int K1_WORDS = 16;
  localparam int T_WORDS = 4;
  localparam int P_WORDS = 4;
  localparam int FULL_WORDS = K0_WORDS + K1_WORDS + T_WORDS + P_WORDS;
  localparam int DATA_WORDS = T_WORDS + P_WORDS;
  localparam int CMD_ENC = 0;
  localparam int CMD_MODE = 1;
  localparam int K0_W = 1024;
  localparam int K1_W = 510;
  localparam int TP_W = 128;
endpackage

// File: rtl/blink_word_shifter.sv
// blink_word_shifter: N-word shift register, words enter at the top so the first word lands LS
module blink_word_shifter #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift,
  input  logic [W-1:0]   din,
  input  logic           load,
  input  logic [W*N-1:0] pdata,
  output logic [W*N-1:0] q,
  output logic [W-1:0]   dout
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= pdata;
    else if (shift) q <= {din, q[W*N-1:W]};
  assign dout = q[W-1:0];
endmodule

// File: rtl/blink_stream_bridge.sv
// blink_stream_bridge: stream-to-cipher bridge, loads operands from s_*, returns the 128-bit result on m_*
module blink_stream_bridge
  import blink_stream_bridge_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [W-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             enc_out,
  output logic [K0_W-1:0]  k0_out,
  output logic [K1_W-1:0]  k1_out,
  output logic [TP_W-1:0]  p_out,
  output logic [TP_W-1:0]  t_out,
  input  logic [TP_W-1:0]  c_in,
  input  logic             busy_unused_guard_n = 1'b1,
  output logic             busy
);
  localparam int WCW = $clog2(LATENCY + 1);
  state_t state, nxt;
  logic enc, mode, up;
  logic [5:0] cnt, idx;
  logic [WCW-1:0] wcnt;
  logic [1:0] scnt;
  logic acc_s, acc_op, acc_m, last, wait_done;
  logic [K0_W-1:0] k0_q;
  logic [K1_WORDS*W-1:0] k1_q;
  logic [TP_W-1:0] t_q, p_q, r_q;
  logic [W-1:0] k0_d, k1_d, t_d, p_d, r_d;
  logic unused_bits;
  assign acc_s = s_valid && s_ready;
  assign acc_op = acc_s && state == LOAD;
  assign acc_m = m_valid && m_ready;
  // data-only frames reuse the full-frame word map starting at the T field
  assign idx = mode ? cnt + 6'(K0_WORDS + K1_WORDS) : cnt;
  assign last = idx == 6'(FULL_WORDS - 1);
  assign wait_done = wcnt == WCW'(LATENCY - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (acc_s ? LOAD : IDLE) :
          state == LOAD ? (acc_op && last ? WAIT : LOAD) :
          state == WAIT ? (wait_done ? SEND : WAIT) :
          (acc_m && scnt == 2'd3 ? IDLE : SEND);
  end
  always_comb begin
    s_ready = up && (state == IDLE || state == LOAD);
    m_valid = state == SEND;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      up <= 1'b0;
      enc <= 1'b0;
      mode <= 1'b0;
      cnt <= '0;
      wcnt <= '0;
      scnt <= '0;
    end else begin
      up <= 1'b1;
      if (state == IDLE && acc_s) begin
        enc <= s_data[CMD_ENC];
        mode <= s_data[CMD_MODE];
        cnt <= '0;
      end else if (acc_op && !last) cnt <= cnt + 6'd1;
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (acc_m) scnt <= scnt + 2'd1;
    end
  blink_word_shifter #(.W(W), .N(K0_WORDS)) u_k0 (
    .clk(clk), .rst(rst), .shift(acc_op && idx < 6'(K0_WORDS)), .din(s_data),
    .load(1'b0), .pdata('0), .q(k0_q), .dout(k0_d)
  );
  blink_word_shifter #(.W(W), .N(K1_WORDS)) u_k1 (
    .clk(clk), .rst(rst),
    .shift(acc_op && idx >= 6'(K0_WORDS) && idx < 6'(K0_WORDS + K1_WORDS)), .din(s_data),
    .load(1'b0), .pdata('0), .q(k1_q), .dout(k1_d)
  );
  blink_word_shifter #(.W(W), .N(T_WORDS)) u_t (
    .clk(clk), .rst(rst),
    .shift(acc_op && idx >= 6'(K0_WORDS + K1_WORDS) && idx < 6'(FULL_WORDS - P_WORDS)), .din(s_data),
    .load(1'b0), .pdata('0), .q(t_q), .dout(t_d)
  );
  blink_word_shifter #(.W(W), .N(P_WORDS)) u_p (
    .clk(clk), .rst(rst), .shift(acc_op && idx >= 6'(FULL_WORDS - P_WORDS)), .din(s_data),
    .load(1'b0), .pdata('0), .q(p_q), .dout(p_d)
  );
  // result is captured on the WAIT->SEND edge and drained LS word first
  blink_word_shifter #(.W(W), .N(TP_W / W)) u_res (
    .clk(clk), .rst(rst), .shift(acc_m), .din('0),
    .load(state == WAIT && wait_done), .pdata(c_in), .q(r_q), .dout(r_d)
  );
  assign enc_out = enc;
  assign k0_out = k0_q;
  assign k1_out = k1_q[K1_W-1:0];
  assign t_out = t_q;
  assign p_out = p_q;
  assign m_data = r_d;
  assign unused_bits = ^{k1_q[K1_WORDS*W-1:K1_W], k0_d, k1_d, t_d, p_d, r_q, busy_unused_guard_n};
endmodule
